// File: rtl/usr_pkg.sv
// Shared types and constants for the universal shift register
// datapath and its serial receiver.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP,
    WAIT_HIGH
  } usr_rx_state_e;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  localparam int USR_WIDTH_DEFAULT = 4;

endpackage

// File: rtl/usr_rx_shifter.sv
// Bidirectional assembly register with a saturating bit counter.
// o_last flags the final data bit; o_done flags a full word.
module usr_rx_shifter
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH_DEFAULT
) (
  input  logic             clc,
  input  logic             clear,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_dir,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_data;

  assign o_data = r_data;
  assign o_done = (r_cnt == CW'(WIDTH));
  assign o_last = (r_cnt == CW'(WIDTH - 1));

  // Clear on load, otherwise shift one bit in until the word is full.
  always_ff @(posedge clc or negedge clear) begin
    if (!clear) begin
      r_cnt  <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_cnt  <= '0;
      r_data <= '0;
    end else if (i_shift && !o_done) begin
      r_cnt <= r_cnt + 1'b1;
      if (i_dir == DIR_MSB)
        r_data <= {r_data[WIDTH-2:0], i_bit};
      else
        r_data <= {i_bit, r_data[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/usr_serial_rx.sv
// Start/data/stop frame receiver with a one-word holding register,
// valid/ready output, sticky overrun and a framing-error pulse.
module usr_serial_rx
  import usr_pkg::*;
#(
  parameter int WIDTH = USR_WIDTH_DEFAULT
) (
  input  logic             clc,
  input  logic             clear,
  input  logic             ser_in,
  input  logic             ser_en,
  input  logic             dir,
  input  logic             out_ready,
  input  logic             ovr_clr,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  output logic             overrun,
  output logic             frame_err
);

  usr_rx_state_e    r_state;
  usr_rx_state_e    w_next;
  logic             r_dir;
  logic [WIDTH-1:0] r_par;
  logic             r_valid;
  logic             r_ovr;
  logic             r_ferr;

  logic             w_load;
  logic             w_shift;
  logic             w_good;
  logic             w_bad;
  logic             w_accept;
  logic [WIDTH-1:0] w_data;
  logic             w_last;
  logic             w_done;

  usr_rx_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clc    (clc),
    .clear  (clear),
    .i_load (w_load),
    .i_shift(w_shift),
    .i_dir  (r_dir),
    .i_bit  (ser_in),
    .o_data (w_data),
    .o_last (w_last),
    .o_done (w_done)
  );

  assign par_out   = r_par;
  assign out_valid = r_valid;
  assign overrun   = r_ovr;
  assign frame_err = r_ferr;

  // A finished word is taken if the slot is empty or being popped now.
  assign w_accept = !r_valid || out_ready;

  // State register plus the direction latched at the start bit.
  always_ff @(posedge clc or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_dir   <= DIR_LSB;
    end else begin
      r_state <= w_next;
      if (w_load)
        r_dir <= dir;
    end
  end

  // Next state and per-strobe control.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    w_good  = 1'b0;
    w_bad   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (ser_en && !ser_in) begin
          w_load = 1'b1;
          w_next = DATA;
        end
      end
      DATA: begin
        if (ser_en) begin
          w_shift = 1'b1;
          if (w_last)
            w_next = STOP;
        end
      end
      STOP: begin
        if (ser_en && w_done) begin
          if (ser_in) begin
            w_good = 1'b1;
            w_next = IDLE;
          end else begin
            w_bad  = 1'b1;
            w_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (ser_en && ser_in)
          w_next = IDLE;
      end
    endcase
  end

  // Holding register, handshake and status flags.
  always_ff @(posedge clc or negedge clear) begin
    if (!clear) begin
      r_par   <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= w_bad;
      if (w_good && w_accept) begin
        r_par   <= w_data;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_good && !w_accept)
        r_ovr <= 1'b1;
      else if (ovr_clr)
        r_ovr <= 1'b0;
    end
  end

endmodule

// File: doc/usr_serial_rx.md
# usr_serial_rx

Serial frame receiver for the universal-shift-register datapath. It samples the serial stream that a `usr` instance shifts out, one bit per strobe, and frames it as start / WIDTH data bits / stop. It assembles the word in either shift direction and presents it on a parallel port with a valid/ready handshake. It is the receiving end of the serial link that `usr` drives through its left/right serial path.

## Interface
- `WIDTH`, default 4: data bits per frame; legal range 2..16.
- `clc`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  asynchronous, active-low reset.
- `ser_in`  in  1  serial line; idles high.
- `ser_en`  in  1  bit strobe; `ser_in` is sampled only on edges where `ser_en`=1.
- `dir`  in  1  0 = LSB-first (right shift), 1 = MSB-first (left shift); latched at the start bit.
- `out_ready`  in  1  consumer accepts the word when `out_valid`=1 and `out_ready`=1.
- `ovr_clr`  in  1  synchronous clear of `overrun`.
- `par_out`  out  WIDTH  received word; held stable while `out_valid`=1.
- `out_valid`  out  1  a word is available.
- `overrun`  out  1  sticky flag: a completed frame was dropped because the holding register was full.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled as 0.

## Operation
- FSM states:
  - IDLE: on a strobe with `ser_in`=0 (start bit), latch `dir`, clear the bit counter, go to DATA. A strobe with `ser_in`=1 is ignored.
  - DATA: on each strobe, shift `ser_in` into the assembly register and increment the counter.
    - `dir`=0: the bit enters at the MSB and shifts right, so the first bit lands in bit 0.
    - `dir`=1: the bit enters at the LSB and shifts left, so the first bit lands in bit WIDTH-1.
    - After WIDTH strobes, go to STOP.
  - STOP: on a strobe:
    - `ser_in`=1: frame is good; deliver the word (rules below) and go to IDLE.
    - `ser_in`=0: pulse `frame_err`, discard the word, go to WAIT_HIGH.
  - WAIT_HIGH: on a strobe with `ser_in`=1, go to IDLE. This prevents a stuck-low line from retriggering.
- Delivery of a good frame:
  - If `out_valid`=0, or `out_valid`=1 with `out_ready`=1 in the same cycle: load `par_out` and set `out_valid`=1.
  - Otherwise: drop the new word, keep `par_out`, and set `overrun`=1.
- A handshake with no new frame completing clears `out_valid`.
- `ovr_clr`=1 clears `overrun`. If `ovr_clr`=1 in the same cycle as a new overrun, the set wins.
- The bit counter is $clog2(WIDTH+1) bits wide and never wraps mid-frame.
- Strobes while `ser_en`=0 cause no state change. The frame may be arbitrarily slow.

## Timing
- Reset values, applied immediately on `clear`=0 and independent of `clc`: state=IDLE, `par_out`=0, `out_valid`=0, `overrun`=0, `frame_err`=0, counter=0, assembly register=0.
- Reset mid-frame abandons the frame with no `frame_err` and no output.
- Latency: `out_valid` rises on the clock edge that samples the stop bit. Minimum frame time is WIDTH+2 strobed cycles.
- Back-to-back: a start bit may be strobed on the cycle immediately after the stop bit.
- `frame_err` is high for exactly the one cycle following the bad stop-bit edge.
- `dir` changes during DATA or STOP have no effect on the current frame.

## Structure
- Package `usr_pkg` holds:
  - the state enum `{IDLE, DATA, STOP, WAIT_HIGH}`;
  - the `DIR_LSB` and `DIR_MSB` constants;
  - `USR_WIDTH_DEFAULT = 4`, shared with `usr`.
- One sub-module, `usr_rx_shifter`: the bidirectional assembly register with its bit counter (load-clear, shift-left, shift-right, and a `done` output at WIDTH).
- The FSM, holding register and flags live in the top module.

## Test plan
- Reset: assert `clear`=0 mid-DATA after 2 bits, then release → all outputs 0, state IDLE. A following full frame is received correctly.
- LSB-first, WIDTH=4, `dir`=0: strobe 0, then 0,1,0,1, then stop 1 → `par_out`=4'b1010 and `out_valid`=1 on the stop edge. `out_ready` pulse → `out_valid`=0.
- MSB-first, `dir`=1: strobe 0, then 1,1,0,0, then 1 → `par_out`=4'b1100. Repeat with `ser_en` gaps of 3 idle cycles between bits → same result.
- Framing error: frame with stop bit 0 → `frame_err` 1-cycle pulse, `out_valid` stays 0. Next strobe with 0 does not start a frame; strobe 1 followed by a good frame 4'b0110 is received.
- Overrun:
  - Receive 4'b0011 with `out_ready`=0, then 4'b0101 → `par_out` stays 4'b0011, `overrun`=1.
  - `ovr_clr` → `overrun`=0.
  - Stop edge coinciding with an `out_ready` pop → new word loaded, `overrun` stays 0.
- Idle noise: strobes with `ser_in`=1 in IDLE for 10 cycles → no state change, no outputs.
